// File: rtl/vram_pkg.sv
// Shared video package: frame geometry, address width and the fixed
// band-to-colour table. Used by the frame store and the VGA timing block.
//   H_PIX     : pixels per row
//   V_PIX     : rows per frame
//   BAND_ROWS : rows per colour band
//   ADDR_W    : width of the linear pixel address
package vram_pkg;

  localparam int H_PIX     = 128;
  localparam int V_PIX     = 96;
  localparam int BAND_ROWS = 24;
  localparam int ADDR_W    = 14;
  localparam int NUM_BANDS = 4;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  localparam rgb_t RGB_BLACK = '{r: 1'b0, g: 1'b0, b: 1'b0};

  // Colour of each horizontal band, top to bottom: red, green, blue, white.
  function automatic rgb_t band_colour(input logic [1:0] band);
    rgb_t c;
    case (band)
      2'd0:    c = '{r: 1'b1, g: 1'b0, b: 1'b0};
      2'd1:    c = '{r: 1'b0, g: 1'b1, b: 1'b0};
      2'd2:    c = '{r: 1'b0, g: 1'b0, b: 1'b1};
      default: c = '{r: 1'b1, g: 1'b1, b: 1'b1};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vram_pattern.sv
// Combinational pixel pattern: maps a linear pixel address to its fixed
// {r,g,b} value. Column does not matter; only the band of the row does.
// Addresses past the end of the frame read black.
//   address : linear pixel index, row*H_PIX + column
//   rgb     : colour of that pixel
module vram_pattern
  import vram_pkg::*;
#(
  parameter int H_PIX     = vram_pkg::H_PIX,
  parameter int V_PIX     = vram_pkg::V_PIX,
  parameter int BAND_ROWS = vram_pkg::BAND_ROWS
) (
  input  logic [ADDR_W-1:0] address,
  output rgb_t              rgb
);

  localparam logic [ADDR_W:0]   PIX_TOTAL = (ADDR_W+1)'(H_PIX * V_PIX);
  localparam logic [ADDR_W-1:0] ROW_DIV   = ADDR_W'(H_PIX);
  localparam logic [ADDR_W-1:0] BAND_DIV  = ADDR_W'(BAND_ROWS);
  localparam logic [ADDR_W-1:0] BAND_LIM  = ADDR_W'(NUM_BANDS);

  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] band;

  assign row  = address / ROW_DIV;
  assign band = row / BAND_DIV;

  // Black is the default; an unknown address makes the range test fail in
  // simulation, so the register downstream never captures X.
  always_comb begin
    rgb = RGB_BLACK;
    if (({1'b0, address} < PIX_TOTAL) && (band < BAND_LIM)) begin
      rgb = band_colour(band[1:0]);
    end
  end

endmodule

// File: rtl/vram.sv
// Read-only 3-bit-per-pixel frame store holding a fixed four-band pattern.
// One-cycle registered read; reset forces the outputs to black.
//   reset   : synchronous active-high reset
//   clk     : rising-edge clock
//   address : linear pixel index, row*H_PIX + column
//   red     : red plane bit of the pixel addressed at the previous edge
//   green   : green plane bit
//   blue    : blue plane bit
module vram
  import vram_pkg::*;
#(
  parameter int H_PIX     = vram_pkg::H_PIX,
  parameter int V_PIX     = vram_pkg::V_PIX,
  parameter int BAND_ROWS = vram_pkg::BAND_ROWS
) (
  input  logic              reset,
  input  logic              clk,
  input  logic [ADDR_W-1:0] address,
  output logic              red,
  output logic              green,
  output logic              blue
);

  rgb_t pix;
  rgb_t rgb_p0;

  vram_pattern #(
    .H_PIX     (H_PIX),
    .V_PIX     (V_PIX),
    .BAND_ROWS (BAND_ROWS)
  ) u_pattern (
    .address (address),
    .rgb     (pix)
  );

  // Stage p0: output register. Reset takes priority over the read.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_p0 <= RGB_BLACK;
    end else begin
      rgb_p0 <= pix;
    end
  end

  assign red   = rgb_p0.r;
  assign green = rgb_p0.g;
  assign blue  = rgb_p0.b;

endmodule

// File: tb/tb_vram.sv
module tb_vram;

  localparam int TB_H    = 128;
  localparam int TB_V    = 96;
  localparam int TB_BAND = 24;

  logic        reset;
  logic        clk;
  logic [13:0] address;
  logic        red, green, blue;

  int checks = 0;
  int fails  = 0;

  vram dut (
    .reset   (reset),
    .clk     (clk),
    .address (address),
    .red     (red),
    .green   (green),
    .blue    (blue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: colour from the frame's band rules.
  function automatic logic [2:0] model(input int a);
    int row;
    if (a >= TB_H * TB_V) return 3'b000;
    row = a / TB_H;
    case (row / TB_BAND)
      0:       return 3'b100;
      1:       return 3'b010;
      2:       return 3'b001;
      default: return 3'b111;
    endcase
  endfunction

  task automatic check(input string tag, input logic [2:0] exp);
    logic [2:0] obs;
    obs = {red, green, blue};
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed rgb=%b expected rgb=%b", tag, obs, exp);
    end
  endtask

  // Drive an address, clock once, check the registered result.
  task automatic read(input string tag, input int a);
    address = 14'(a);
    @(posedge clk);
    #1;
    check(tag, model(a));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] held;
    int a;
    reset   = 1'b1;
    address = 14'h0001;

    // Reset held for two edges
    @(posedge clk); #1; check("reset_c1", 3'b000);
    @(posedge clk); #1; check("reset_c2", 3'b000);
    reset = 1'b0;
    @(posedge clk); #1; check("release_first", 3'b100);

    // Directed band and boundary reads
    read("a1", 1);
    read("a8", 8);
    read("a128", 128);
    read("a256", 256);
    read("a1092", 1092);
    read("a3071", 3071);
    read("a3072", 3072);
    read("a4096", 4096);
    read("a9215", 9215);
    read("a9216", 9216);
    read("a9217", 9217);
    read("a9218", 9218);
    read("a9220", 9220);
    read("a9224", 9224);
    read("a12032", 12032);
    read("a12035", 12035);
    read("a12287", 12287);
    read("a12288", 12288);
    read("a16383", 16383);
    read("a6143", 6143);
    read("a6144", 6144);

    // Hold: output stable over several edges, and an address change
    // between edges has no effect until the next edge
    read("hold_set", 3072);
    held = {red, green, blue};
    @(posedge clk); #1; check("hold_1", held);
    @(posedge clk); #1; check("hold_2", held);
    #2 address = 14'd0;
    #1 check("mid_cycle", held);
    @(posedge clk); #1; check("after_edge", model(0));

    // Reset mid-sequence overrides a read
    address = 14'd9216;
    reset   = 1'b1;
    @(posedge clk); #1; check("mid_reset", 3'b000);
    reset = 1'b0;
    @(posedge clk); #1; check("post_reset", model(9216));

    // Back-to-back walk across band boundaries
    for (int i = 3060; i < 3085; i++) read("walk_rg", i);
    for (int i = 12280; i < 12296; i++) read("walk_end", i);

    // Random reads
    for (int i = 0; i < 400; i++) begin
      a = int'($urandom_range(0, 16383));
      read("rand", a);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/vram.md
VRAM -- requirements
Module: vram

Interface
REQ-001 The block SHALL use one clock, clk; reset is synchronous and active-high.
REQ-002 Parameter H_PIX, default 128: pixels per row.
REQ-003 Parameter V_PIX, default 96: rows per frame.
REQ-004 Parameter BAND_ROWS, default 24: rows per colour band.
REQ-005 Port reset, input, 1 bit: synchronous active-high reset; positional port 1.
REQ-006 Port clk, input, 1 bit: rising-edge clock; positional port 2.
REQ-007 Port address, input, 14 bits: linear pixel index, row*H_PIX + column; positional port 3.
REQ-008 Port red, output, 1 bit: red plane bit of the addressed pixel; positional port 4.
REQ-009 Port green, output, 1 bit: green plane bit; positional port 5.
REQ-010 Port blue, output, 1 bit: blue plane bit; positional port 6.

Function
REQ-011 The block SHALL be a read-only 3-bit-per-pixel frame store of H_PIX*V_PIX = 12288 locations, one bit plane per colour.
REQ-012 Read latency SHALL be exactly 1 clk: red/green/blue after rising edge N reflect address sampled at edge N.
REQ-013 Outputs SHALL be registered and SHALL hold between edges; address changes between edges have no effect until the next edge.
REQ-014 row = address / H_PIX (address[13:7] at default); column = address mod H_PIX (address[6:0]).
REQ-015 Rows 0..23 SHALL read red=1, green=0, blue=0.
REQ-016 Rows 24..47 SHALL read red=0, green=1, blue=0.
REQ-017 Rows 48..71 SHALL read red=0, green=0, blue=1.
REQ-018 Rows 72..95 SHALL read red=1, green=1, blue=1 (white).
REQ-019 Band contents SHALL be independent of column.
REQ-020 Addresses >= 12288 (row >= V_PIX) SHALL read 0,0,0 (black); no wrap-around.
REQ-021 An X or unknown address SHALL never be stored; outputs update only from a sampled known address.
REQ-022 There SHALL be no write port; contents are fixed by REQ-015..REQ-018.

Reset
REQ-023 While reset is 1 at a rising edge, red, green and blue SHALL be 0 on the following cycle, regardless of address.
REQ-024 On the first edge with reset=0, normal reads SHALL resume with 1-cycle latency; no extra warm-up cycles.
REQ-025 Reset asserted mid-sequence SHALL override any read in the same cycle.
REQ-026 Before the first reset, output values are don't-care.

Structure
REQ-027 H_PIX, V_PIX, BAND_ROWS, ADDR_W=14 and the band-to-colour table SHALL live in a shared video package, reused by the VGA timing block.
REQ-028 One sub-module, vram_pattern, SHALL compute the combinational {r,g,b} from address; vram registers its result.
REQ-029 The implementation SHALL be synthesizable as ROM or logic; no initial blocks or $readmemh are needed.

Verification
REQ-030 Reset=1 for 2 cycles with address=14'h0001 -> outputs 0,0,0; first cycle after release -> 1,0,0.
REQ-031 Addresses 1, 8, 128, 256 (rows 0..2) -> 1,0,0 one cycle later; address 1092 (row 8) -> 1,0,0.
REQ-032 Address 3071 (row 23) -> 1,0,0; 3072 (row 24) -> 0,1,0; 4096 (row 32) -> 0,1,0.
REQ-033 Address 9215 (row 71) -> 0,0,1; 9216 (row 72) -> 1,1,1; 9217, 9218, 9220, 9224 -> 1,1,1.
REQ-034 Addresses 12032 and 12035 (row 94) -> 1,1,1; 12287 -> 1,1,1; 12288 and 16383 -> 0,0,0.
REQ-035 A back-to-back address change every cycle -> each output equals the pattern of the previous cycle's address; address held -> outputs stable.
